// File: rtl/fifo_burst_reader.sv
// rtl/fifo_burst_reader.sv - burst read engine between a synchronous FIFO and a valid/ready stream
// Pops fixed-length bursts, or partial bursts on flush/timeout, into a registered output beat.
module fifo_burst_reader #(
   parameter int WIDTH     = 32,
   parameter int DEPTH     = 16,
   parameter int BURST_LEN = 4,
   parameter int TIMEOUT   = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [$clog2(DEPTH):0]   fifo_count,
   input  logic                     fifo_empty,
   input  logic [WIDTH-1:0]         fifo_rd_data,
   output logic                     fifo_pop,
   input  logic                     flush,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic [WIDTH-1:0]         m_data,
   output logic                     m_last,
   output logic                     busy
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int RW = $clog2(BURST_LEN) + 1;
   localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] BURST_C = CW'(BURST_LEN);
   localparam logic [TW-1:0] TMAX_C  = TW'(TIMEOUT);

   typedef enum logic {IDLE, STREAM} state_t;

   state_t            state_q, state_d;
   logic [RW-1:0]     remaining_q, remaining_d;
   logic [TW-1:0]     timer_q, timer_d;
   logic              m_valid_q, m_valid_d;
   logic              m_last_q, m_last_d;
   logic [WIDTH-1:0]  m_data_q, m_data_d;
   logic              pop;
   logic              timed_out;

   // A stalled output beat blocks popping, so the register never gets overwritten.
   assign pop = (state_q == STREAM) && (remaining_q != '0) && !fifo_empty
                && (!m_valid_q || m_ready);
   assign timed_out = (TIMEOUT != 0) && (timer_q >= TMAX_C);

   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      timer_d     = timer_q;
      m_valid_d   = m_valid_q;
      m_last_d    = m_last_q;
      m_data_d    = m_data_q;

      case (state_q)
         IDLE: begin
            if (fifo_count >= BURST_C) begin
               state_d     = STREAM;
               remaining_d = RW'(BURST_LEN);
               timer_d     = '0;
            end else if (fifo_count != '0 && (flush || timed_out)) begin
               state_d     = STREAM;
               remaining_d = fifo_count[RW-1:0];
               timer_d     = '0;
            end else if (fifo_count == '0) begin
               timer_d = '0;
            end else if (timer_q < TMAX_C) begin
               timer_d = timer_q + TW'(1);
            end
         end
         STREAM: begin
            timer_d = '0;
            if (pop) begin
               remaining_d = remaining_q - RW'(1);
               if (remaining_q == RW'(1)) begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (pop) begin
         m_data_d  = fifo_rd_data;
         m_valid_d = 1'b1;
         m_last_d  = (remaining_q == RW'(1));
      end else if (m_valid_q && m_ready) begin
         m_valid_d = 1'b0;
         m_last_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         remaining_q <= '0;
         timer_q     <= '0;
         m_valid_q   <= 1'b0;
         m_last_q    <= 1'b0;
         m_data_q    <= '0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         timer_q     <= timer_d;
         m_valid_q   <= m_valid_d;
         m_last_q    <= m_last_d;
         m_data_q    <= m_data_d;
      end
   end

   assign fifo_pop = pop;
   assign busy     = (state_q == STREAM);
   assign m_valid  = m_valid_q;
   assign m_last   = m_last_q;
   assign m_data   = m_data_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb/tb_fifo_burst_reader.sv - directed bench for fifo_burst_reader with a behavioural FIFO
module tb_fifo_burst_reader;

   localparam int WIDTH     = 32;
   localparam int DEPTH     = 16;
   localparam int BURST_LEN = 4;
   localparam int TIMEOUT   = 64;

   logic              clk;
   logic              rst;
   logic [4:0]        fifo_count;
   logic              fifo_empty;
   logic [WIDTH-1:0]  fifo_rd_data;
   logic              fifo_pop;
   logic              flush;
   logic              m_valid;
   logic              m_ready;
   logic [WIDTH-1:0]  m_data;
   logic              m_last;
   logic              busy;

   fifo_burst_reader #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .BURST_LEN(BURST_LEN), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst),
      .fifo_count(fifo_count), .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data),
      .fifo_pop(fifo_pop), .flush(flush),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
      .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural synchronous FIFO; it is deliberately not reset by rst.
   logic [WIDTH-1:0] mem [DEPTH];
   logic [3:0]       rd_ptr = '0;
   logic [3:0]       wr_ptr = '0;
   logic [4:0]       cnt    = '0;
   logic             push_en;
   logic [WIDTH-1:0] push_data;

   always @(posedge clk) begin
      if (push_en) begin
         mem[wr_ptr] <= push_data;
         wr_ptr      <= wr_ptr + 4'd1;
      end
      if (fifo_pop) rd_ptr <= rd_ptr + 4'd1;
      cnt <= cnt + 5'(push_en) - 5'(fifo_pop);
   end

   assign fifo_count   = cnt;
   assign fifo_empty   = (cnt == 5'd0);
   assign fifo_rd_data = mem[rd_ptr];

   int               cyc = 0;
   logic [WIDTH-1:0] beat_data [$];
   logic             beat_last [$];
   int               beat_cyc  [$];
   int               pop_cnt    = 0;
   int               stall_viol = 0;
   int               hold_viol  = 0;
   logic             prev_stall = 1'b0;
   logic [WIDTH-1:0] prev_data  = '0;
   logic             prev_last  = 1'b0;

   always @(negedge clk) begin
      if (rst) begin
         prev_stall <= 1'b0;
      end else begin
         if (m_valid && m_ready) begin
            beat_data.push_back(m_data);
            beat_last.push_back(m_last);
            beat_cyc.push_back(cyc);
         end
         if (fifo_pop) pop_cnt <= pop_cnt + 1;
         if (fifo_pop && m_valid && !m_ready) stall_viol <= stall_viol + 1;
         if (prev_stall && (m_data !== prev_data || m_last !== prev_last))
            hold_viol <= hold_viol + 1;
         prev_stall <= m_valid && !m_ready;
         prev_data  <= m_data;
         prev_last  <= m_last;
      end
   end

   int   vectors    = 0;
   int   miscompares = 0;
   logic pat_en     = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (pat_en) m_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
   endtask

   task automatic push_words(input int n, input logic [WIDTH-1:0] base);
      for (int i = 0; i < n; i++) begin
         push_en   = 1'b1;
         push_data = base + WIDTH'(i);
         tick();
      end
      push_en = 1'b0;
   endtask

   task automatic wait_beats(input string tag, input int n, input int bound);
      int k;
      k = 0;
      while (beat_data.size() < n && k < bound) begin
         tick();
         k++;
      end
      check(tag, beat_data.size(), n);
   endtask

   task automatic wait_pop(output int n);
      n = 0;
      while (!fifo_pop && n < 300) begin
         tick();
         n++;
      end
   endtask

   initial begin
      int b, p, s, h, n;
      rst = 1'b1; flush = 1'b0; m_ready = 1'b0; push_en = 1'b0; push_data = '0;

      // Reset with random control inputs
      for (int i = 0; i < 3; i++) begin
         tick();
         m_ready = 1'($urandom_range(0, 1));
         flush   = 1'($urandom_range(0, 1));
         #1;
         check("rst_m_valid", m_valid, 0);
         check("rst_m_last", m_last, 0);
         check("rst_m_data", m_data, 0);
         check("rst_fifo_pop", fifo_pop, 0);
         check("rst_busy", busy, 0);
      end
      rst = 1'b0; flush = 1'b1; m_ready = 1'b1;
      p = pop_cnt; b = beat_data.size();
      repeat (20) tick();
      flush = 1'b0;
      check("empty_idle_pops", pop_cnt - p, 0);
      check("empty_idle_beats", beat_data.size() - b, 0);
      check("empty_idle_busy", busy, 0);
      check("empty_idle_valid", m_valid, 0);

      // Full burst, m_ready held high
      b = beat_data.size(); p = pop_cnt;
      push_words(4, 32'hA000_0000);
      n = 0;
      while (!m_valid && n < 20) begin tick(); n++; end
      check("t2_latency", n, 2);
      wait_beats("t2_beats", b + 4, 40);
      for (int i = 0; i < 4; i++) begin
         check("t2_data", beat_data[b+i], 32'hA000_0000 + i);
         check("t2_last", beat_last[b+i], (i == 3));
         check("t2_b2b", beat_cyc[b+i] - beat_cyc[b], i);
      end
      check("t2_pops", pop_cnt - p, 4);

      // Two bursts under a 1,0,0,1 ready pattern
      repeat (3) tick();
      b = beat_data.size(); p = pop_cnt; s = stall_viol; h = hold_viol;
      pat_en = 1'b1;
      push_words(8, 32'hB000_0000);
      wait_beats("t3_beats", b + 8, 200);
      pat_en = 1'b0; m_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check("t3_data", beat_data[b+i], 32'hB000_0000 + i);
         check("t3_last", beat_last[b+i], (i == 3) || (i == 7));
      end
      check("t3_pops", pop_cnt - p, 8);
      check("t3_pop_in_stall", stall_viol - s, 0);
      check("t3_hold", hold_viol - h, 0);

      // Partial burst forced by the idle timeout
      repeat (3) tick();
      b = beat_data.size();
      push_words(2, 32'hC000_0000);
      wait_pop(n);
      check("t4_timeout_wait", n, TIMEOUT);
      wait_beats("t4_beats", b + 2, 20);
      check("t4_data0", beat_data[b], 32'hC000_0000);
      check("t4_last0", beat_last[b], 0);
      check("t4_data1", beat_data[b+1], 32'hC000_0001);
      check("t4_last1", beat_last[b+1], 1);
      repeat (2) tick();
      check("t4_timer_clear", dut.timer_q, 0);
      check("t4_busy", busy, 0);

      // Flush forces an immediate partial burst
      b = beat_data.size();
      push_words(3, 32'hD000_0000);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("t5_pop_now", fifo_pop, 1);
      check("t5_busy", busy, 1);
      wait_beats("t5_beats", b + 3, 20);
      for (int i = 0; i < 3; i++) begin
         check("t5_data", beat_data[b+i], 32'hD000_0000 + i);
         check("t5_last", beat_last[b+i], (i == 2));
      end
      repeat (3) tick();
      b = beat_data.size(); p = pop_cnt;
      flush = 1'b1;
      repeat (5) tick();
      flush = 1'b0;
      check("t5_empty_flush_busy", busy, 0);
      check("t5_empty_flush_pops", pop_cnt - p, 0);
      check("t5_empty_flush_beats", beat_data.size() - b, 0);

      // Reset mid-burst, leftover words drain after a timeout
      b = beat_data.size();
      push_words(5, 32'hE000_0000);
      repeat (3) tick();
      rst = 1'b1;
      #1;
      check("t6_rst_valid", m_valid, 0);
      check("t6_rst_busy", busy, 0);
      check("t6_rst_pop", fifo_pop, 0);
      check("t6_pre_beats", beat_data.size() - b, 2);
      check("t6_pre_data0", beat_data[b], 32'hE000_0000);
      check("t6_pre_data1", beat_data[b+1], 32'hE000_0001);
      check("t6_fifo_left", fifo_count, 2);
      tick();
      rst = 1'b0;
      wait_pop(n);
      check("t6_timeout_wait", n, TIMEOUT + 1);
      wait_beats("t6_beats", b + 4, 20);
      check("t6_data3", beat_data[b+2], 32'hE000_0003);
      check("t6_last3", beat_last[b+2], 0);
      check("t6_data4", beat_data[b+3], 32'hE000_0004);
      check("t6_last4", beat_last[b+3], 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
Read-side engine for the team's synchronous FIFO. It watches the FIFO occupancy, pops words in fixed-length bursts (or shorter partial bursts on flush or timeout), and presents them on a registered valid/ready output stream with a last marker per burst. It sits between a FIFO's pop/rd_data/empty/count interface and a downstream packet consumer.

Parameters:
WIDTH, 32, data word width; must match the FIFO.
DEPTH, 16, FIFO depth; sets fifo_count width to $clog2(DEPTH)+1.
BURST_LEN, 4, beats per full burst; legal range 1..DEPTH.
TIMEOUT, 64, idle cycles with a non-empty, sub-burst FIFO before a partial burst is forced; 0 disables the timeout.

Ports:
clk  input  1  clock; all logic on rising edge.
rst  input  1  asynchronous reset, active-high.
fifo_count  input  $clog2(DEPTH)+1  FIFO occupancy.
fifo_empty  input  1  FIFO empty flag.
fifo_rd_data  input  WIDTH  FIFO head word (combinational read; valid when not empty).
fifo_pop  output  1  pop strobe; FIFO advances on the clk edge where it is high.
flush  input  1  level; requests a partial burst of the current contents while idle.
m_valid  output  1  output beat valid.
m_ready  input  1  downstream accept.
m_data  output  WIDTH  output beat data.
m_last  output  1  final beat of the current burst.
busy  output  1  high while in STREAM.

Behaviour:
- Reset (async, rst=1): state=IDLE, remaining=0, timer=0, m_valid=0, m_last=0, m_data=0. Combinational fifo_pop=0 and busy=0 while in reset.
- FSM states: IDLE and STREAM. Internal counter remaining has width $clog2(BURST_LEN)+1.
- IDLE, checked in priority order:
  (1) fifo_count>=BURST_LEN: go to STREAM, remaining<=BURST_LEN.
  (2) Otherwise, if fifo_count!=0 and (flush or (TIMEOUT!=0 and timer>=TIMEOUT)): go to STREAM, remaining<=fifo_count.
  (3) Otherwise stay in IDLE.
- Timer:
  - Increments, saturating at TIMEOUT, each cycle in IDLE with 0<fifo_count<BURST_LEN.
  - Clears on any IDLE exit, in STREAM, and when fifo_count==0.
- STREAM:
  - fifo_pop = (remaining!=0) and !fifo_empty and (!m_valid or m_ready). This is combinational on m_ready.
  - On pop:
    - m_data<=fifo_rd_data, m_valid<=1.
    - m_last<=(remaining==1).
    - remaining<=remaining-1.
  - On a pop with remaining==1, go to IDLE on the same edge.
  - An empty FIFO in STREAM stalls without popping. This cannot happen for correctly sized bursts.
- Output register (both states):
  - If m_valid and m_ready and no pop, then m_valid<=0 and m_last<=0.
  - While m_valid and !m_ready, m_data and m_last hold stable and fifo_pop=0.
- Throughput and latency:
  - With m_ready held high, bursts run at 1 beat/cycle.
  - Start condition seen at edge N, STREAM and first pop in cycle N+1, m_valid high in cycle N+2.
- A pending last beat may remain in the output register while the FSM is back in IDLE. A new burst may start, but its first pop waits for that beat's acceptance.
- flush is ignored in STREAM and has no effect when fifo_count==0.
- Reset mid-burst aborts the burst: the in-flight m_valid beat is dropped, and words already popped are lost. Unpopped words remain in the FIFO and are handled by the normal IDLE rules after reset release.

Test Plan:
1. Assert rst with random inputs -> m_valid=0, m_last=0, m_data=0, fifo_pop=0, busy=0. Release rst with FIFO empty -> outputs stay 0 indefinitely.
2. Push A0..A3 into the FIFO with m_ready=1 (BURST_LEN=4) -> four consecutive pops, then four consecutive m_valid beats A0,A1,A2,A3. m_last is high only on A3, and the first m_valid comes 2 cycles after count reaches 4.
3. Push 8 words with m_ready toggling 1,0,0,1,... -> no pop in any cycle with m_valid&&!m_ready, and m_data is held across stalls. Output is two bursts of 4 with m_last on beats 4 and 8, and there is no loss or duplication.
4. Push 2 words with TIMEOUT=64 and no flush -> no pop for 64 idle cycles, then a partial burst of 2 with m_last on the 2nd beat; timer returns to 0.
5. Push 3 words and pulse flush for 1 cycle -> immediate burst of 3 with m_last on the 3rd beat. Flush with an empty FIFO -> no activity.
6. Start a 4-beat burst, accept 2 beats, then assert rst for 1 cycle with 2 words left in the FIFO -> m_valid and busy drop immediately. After release, those 2 words are emitted as a partial burst only after TIMEOUT cycles.
